// File: rtl/btn_int_conditioner.sv
// Push-button conditioner: per-channel 2-FF synchronizer, counter debouncer,
// rising-edge strobe and sticky interrupt request cleared by a CPU acknowledge.
module btn_int_conditioner #(
  parameter int NCH             = 5,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] btn_i,
  input  logic [NCH-1:0] ack_i,
  output logic [NCH-1:0] level_o,
  output logic [NCH-1:0] pulse_o,
  output logic [NCH-1:0] int_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [NCH-1:0] sync1_r;
  logic [NCH-1:0] sync2_r;
  logic [NCH-1:0] level_r;
  logic [NCH-1:0] pulse_r;
  logic [NCH-1:0] int_r;
  logic [CNT_W-1:0] cnt_r [NCH];

  logic [NCH-1:0] flip_s;
  logic [NCH-1:0] rise_s;
  logic [NCH-1:0] int_nxt_s;
  logic [CNT_W-1:0] cnt_nxt_s [NCH];

  // Debounce decision: count while the synchronized input disagrees with level
  always_comb begin
    flip_s = {NCH{1'b0}};
    for (int i = 0; i < NCH; i++) begin
      cnt_nxt_s[i] = {CNT_W{1'b0}};
      if (sync2_r[i] != level_r[i]) begin
        if (cnt_r[i] == CNT_MAX) begin
          flip_s[i]    = 1'b1;
          cnt_nxt_s[i] = {CNT_W{1'b0}};
        end else begin
          flip_s[i]    = 1'b0;
          cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
        end
      end else begin
        flip_s[i]    = 1'b0;
        cnt_nxt_s[i] = {CNT_W{1'b0}};
      end
    end
    // A new press wins over a same-cycle acknowledge so no event is lost
    rise_s    = flip_s & sync2_r;
    int_nxt_s = rise_s | (int_r & ~ack_i);
  end

  // State registers: synchronizer, debounce counters and all outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= {NCH{1'b0}};
      sync2_r <= {NCH{1'b0}};
      level_r <= {NCH{1'b0}};
      pulse_r <= {NCH{1'b0}};
      int_r   <= {NCH{1'b0}};
      for (int i = 0; i < NCH; i++) begin
        cnt_r[i] <= {CNT_W{1'b0}};
      end
    end else begin
      sync1_r <= btn_i;
      sync2_r <= sync1_r;
      level_r <= level_r ^ flip_s;
      pulse_r <= rise_s;
      int_r   <= int_nxt_s;
      for (int i = 0; i < NCH; i++) begin
        cnt_r[i] <= cnt_nxt_s[i];
      end
    end
  end

  assign level_o = level_r;
  assign pulse_o = pulse_r;
  assign int_o   = int_r;

endmodule

// File: tb/tb_btn_int_conditioner.sv
// Scoreboard bench for btn_int_conditioner: a sliding-window reference model
// predicts every cycle's outputs; a monitor compares them against the DUT.
module tb_btn_int_conditioner;

  localparam int NCH = 5;
  localparam int DC  = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [NCH-1:0] btn_i = '0;
  logic [NCH-1:0] ack_i = '0;
  logic [NCH-1:0] level_o;
  logic [NCH-1:0] pulse_o;
  logic [NCH-1:0] int_o;

  btn_int_conditioner #(.NCH(NCH), .DEBOUNCE_CYCLES(DC)) dut (
    .clk(clk), .rst(rst), .btn_i(btn_i), .ack_i(ack_i),
    .level_o(level_o), .pulse_o(pulse_o), .int_o(int_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  logic [3*NCH-1:0] exp_q [$];
  logic [NCH-1:0]   hist [$];
  logic [NCH-1:0]   m_level = '0;
  logic [NCH-1:0]   m_pulse = '0;
  logic [NCH-1:0]   m_int   = '0;

  int             cyc = 0;
  logic [NCH-1:0] lvl_prev = '0;
  int             pulse_cnt [NCH];
  int             rise_cyc [NCH];
  int             fall_cyc [NCH];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Reference model: level toggles once the last DC synchronized samples
  // (raw samples delayed two edges) all disagree with it.
  task automatic model_step(input logic [NCH-1:0] b, input logic [NCH-1:0] a, input logic r);
    int n;
    int idx;
    logic all_diff;
    logic v;
    logic rise;
    if (r) begin
      hist.delete();
      m_level = '0;
      m_pulse = '0;
      m_int   = '0;
    end else begin
      hist.push_back(b);
      n = hist.size();
      for (int ch = 0; ch < NCH; ch++) begin
        all_diff = 1'b1;
        for (int i = 0; i < DC; i++) begin
          idx = n - 3 - i;
          v = (idx >= 0) ? hist[idx][ch] : 1'b0;
          if (v == m_level[ch]) all_diff = 1'b0;
        end
        rise = all_diff && !m_level[ch];
        if (all_diff) m_level[ch] = ~m_level[ch];
        m_pulse[ch] = rise;
        if (rise) m_int[ch] = 1'b1;
        else if (a[ch]) m_int[ch] = 1'b0;
      end
    end
  endtask

  task automatic clear_obs();
    for (int ch = 0; ch < NCH; ch++) begin
      pulse_cnt[ch] = 0;
      rise_cyc[ch]  = -1;
      fall_cyc[ch]  = -1;
    end
  endtask

  // One clock cycle: record what the previous edge produced, drive new inputs, predict.
  task automatic cycle(input logic [NCH-1:0] b, input logic [NCH-1:0] a, input logic r);
    @(negedge clk);
    for (int ch = 0; ch < NCH; ch++) begin
      if (pulse_o[ch]) pulse_cnt[ch]++;
      if (level_o[ch] && !lvl_prev[ch] && rise_cyc[ch] < 0) rise_cyc[ch] = cyc;
      if (!level_o[ch] && lvl_prev[ch] && fall_cyc[ch] < 0) fall_cyc[ch] = cyc;
    end
    lvl_prev = level_o;
    cyc++;
    btn_i = b;
    ack_i = a;
    rst   = r;
    model_step(b, a, r);
    exp_q.push_back({m_level, m_pulse, m_int});
  endtask

  task automatic run(input logic [NCH-1:0] b, input logic [NCH-1:0] a, input logic r, input int n);
    for (int i = 0; i < n; i++) cycle(b, a, r);
  endtask

  // Monitor: every edge the DUT presents a new output word
  initial begin
    logic [3*NCH-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({level_o, pulse_o, int_o} === e) passes++;
        else $display("FAIL outputs @%0t: got lvl=%b pls=%b int=%b, expected lvl=%b pls=%b int=%b",
                      $time, level_o, pulse_o, int_o, e[14:10], e[9:5], e[4:0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    int t;
    logic [NCH-1:0] rb;
    logic [NCH-1:0] ra;
    logic rr;
    clear_obs();
    run(5'b00000, 5'b00000, 1'b1, 3);

    // Clean press on channel 0, held well beyond the latency with no ack
    clear_obs();
    t = cyc;
    run(5'b00001, 5'b00000, 1'b0, 26);
    chk("press_latency", rise_cyc[0] - t, 6);
    chk("press_pulses", pulse_cnt[0], 1);
    run(5'b00000, 5'b00000, 1'b0, 10);

    // Bounce of 3-cycle segments on channel 1, then a steady hold
    clear_obs();
    run(5'b00010, 5'b00000, 1'b0, 3);
    run(5'b00000, 5'b00000, 1'b0, 3);
    run(5'b00010, 5'b00000, 1'b0, 3);
    run(5'b00000, 5'b00000, 1'b0, 3);
    t = cyc;
    run(5'b00010, 5'b00000, 1'b0, 12);
    chk("bounce_latency", rise_cyc[1] - t, 6);
    chk("bounce_pulses", pulse_cnt[1], 1);

    // Ack on channel 2 collides with its second rising event
    run(5'b00110, 5'b00000, 1'b0, 10);
    run(5'b00010, 5'b00000, 1'b0, 10);
    for (int i = 1; i <= 8; i++) begin
      cycle(5'b00110, (i == 6) ? 5'b00100 : 5'b00000, 1'b0);
      if (i == 6) begin
        @(posedge clk);
        #1;
        chk("collision_int", int'(int_o[2]), 1);
      end
    end
    cycle(5'b00110, 5'b00100, 1'b0);
    @(posedge clk);
    #1;
    chk("ack_clear", int'(int_o[2]), 0);

    // Release on channel 3 is debounced but raises nothing
    run(5'b00000, 5'b11111, 1'b0, 8);
    clear_obs();
    run(5'b01000, 5'b00000, 1'b0, 10);
    cycle(5'b01000, 5'b01000, 1'b0);
    clear_obs();
    t = cyc;
    run(5'b00000, 5'b00000, 1'b0, 10);
    chk("release_latency", fall_cyc[3] - t, 6);
    chk("release_pulses", pulse_cnt[3], 0);

    // Channels 0 and 4 pressed together
    clear_obs();
    t = cyc;
    run(5'b10001, 5'b00000, 1'b0, 10);
    chk("simul_latency0", rise_cyc[0] - t, 6);
    chk("simul_latency4", rise_cyc[4] - t, 6);

    // Asynchronous reset mid-cycle with everything pressed
    run(5'b00000, 5'b11111, 1'b0, 8);
    run(5'b11111, 5'b00000, 1'b0, 10);
    cycle(5'b11111, 5'b00000, 1'b1);
    #1;
    chk("async_reset", int'({level_o, pulse_o, int_o}), 0);
    run(5'b11111, 5'b00000, 1'b1, 2);
    run(5'b00000, 5'b00000, 1'b0, 4);

    // Reset during a debounce, released with channel 0 still held
    clear_obs();
    run(5'b00001, 5'b00000, 1'b0, 3);
    run(5'b00001, 5'b00000, 1'b1, 3);
    chk("reset_pulses", pulse_cnt[0], 0);
    clear_obs();
    t = cyc;
    run(5'b00001, 5'b00000, 1'b0, 10);
    chk("reset_latency", rise_cyc[0] - t, 6);
    chk("reset_after_pulses", pulse_cnt[0], 1);

    // Randomized toggling, acknowledges and occasional resets
    rb = '0;
    for (int i = 0; i < 500; i++) begin
      for (int ch = 0; ch < NCH; ch++) begin
        if ($urandom_range(5) == 0) rb[ch] = ~rb[ch];
        ra[ch] = ($urandom_range(9) == 0);
      end
      rr = ($urandom_range(299) == 0);
      cycle(rb, ra, rr);
    end

    run(5'b00000, 5'b00000, 1'b0, 2);
    @(posedge clk);
    #2;
    chk("drain", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/btn_int_conditioner.md
Name: btn_int_conditioner

Overview:
- Conditions raw push-button pins into clean interrupt requests for the CPU block's INT1..INT5 inputs.
- Sits directly upstream of the CPU block design, between the board buttons (BTNC/U/L/R/D) and the interrupt lines.
- Per channel: 2-FF synchronizer, counter-based debouncer, rising-edge detector and sticky pending flag cleared by a CPU acknowledge.

Parameters:
- NCH, 5, number of independent button channels.
- DEBOUNCE_CYCLES, 1000000, cycles a synchronized input must stay different from the debounced state before it is accepted (10 ms at 100 MHz). Legal range is 2 or more.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), debounce counter width. Derived; do not override.

Ports:
- clk  input  1  system clock, 100 MHz; all logic on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- btn_i  input  NCH  raw button pins, active-high, asynchronous to clk.
- ack_i  input  NCH  per-channel interrupt acknowledge, synchronous to clk, level-sampled each cycle.
- level_o  output  NCH  debounced button state.
- pulse_o  output  NCH  one-cycle strobe on each debounced 0->1 transition.
- int_o  output  NCH  sticky interrupt request, feeds the CPU INT lines.

Behaviour:
- Reset: all synchronizer flops, counters, level_o, pulse_o and int_o go to 0 immediately on rst assertion, independent of clk.
- Reset mid-debounce discards the partial count. After release, a button still held is treated as a fresh press and produces one event after full latency.
- Synchronizer: s1 <= btn_i, s2 <= s1 per channel. No logic between the two stages. s2 is the debouncer input.
- Debouncer, per channel, two implicit states:
  - STABLE (s2 == level): counter held at 0.
  - CHANGING (s2 != level): counter increments each cycle.
  - When s2 != level and counter == DEBOUNCE_CYCLES-1, on that edge level <= s2 and counter <= 0.
  - If s2 returns to level before the threshold, counter <= 0 on that edge. A glitch shorter than DEBOUNCE_CYCLES never changes level.
- Latency: if s2 first differs from level in cycle t0 and holds, level_o changes in cycle t0+DEBOUNCE_CYCLES. From btn_i, this is 2+DEBOUNCE_CYCLES cycles after the first sampling edge.
- Release (1->0) is debounced identically but generates no pulse and no interrupt.
- pulse_o is registered. It is high for exactly the one cycle in which level_o first reads 1 after being 0, and low otherwise.
- int_o, per channel, evaluated in this order each edge:
  - If the debounced rising event occurs this edge: int_o <= 1.
  - Else if ack_i == 1: int_o <= 0.
  - Else int_o holds.
  - Simultaneous rising event and ack: int_o stays/becomes 1, so the new event is not lost.
  - Ack while int_o == 0 has no effect.
  - Multiple presses before ack collapse into one pending request (no counting).
- Channels are fully independent. Per-channel counter width is CNT_W and the counter never exceeds DEBOUNCE_CYCLES-1, so there is no wrap.
- Fully synchronous to clk apart from the async reset and the btn_i inputs. All outputs come directly from flops.

Test Plan (DEBOUNCE_CYCLES=4, NCH=5):
- Reset values: assert rst mid-cycle with btn_i=5'b11111 -> level_o, pulse_o and int_o read 0 immediately, before the next clk edge.
- Clean press: btn_i[0] 0->1 and held -> level_o[0]=1 exactly 6 cycles after the first sampling edge. pulse_o[0]=1 for exactly 1 cycle, coincident with the level rise. int_o[0]=1 from that cycle, and it stays 1 for 20 further cycles with ack_i=0.
- Bounce rejection: btn_i[1] toggles 1,0,1,0 for 3 cycles each, then holds at 1 -> level_o[1] stays 0 throughout the bounce. It rises exactly once, 6 cycles after the final 0->1. Exactly one pulse_o[1].
- Ack/event collision: int_o[2]=1, then press and release channel 2 again, timing ack_i[2]=1 for the single cycle whose edge produces the second rising event -> int_o[2] remains 1. A later lone ack_i[2] pulse clears it to 0 on the following edge.
- Release and independence: hold btn_i[3]=1 until int_o[3]=1, ack it, then release -> level_o[3] drops after 6 cycles, and pulse_o[3] and int_o[3] stay 0. Pressing channels 0 and 4 in the same cycle raises int_o[0] and int_o[4] in the same cycle; the other channels stay 0.
- Reset mid-operation: press btn_i[0], assert rst 3 cycles later, release rst with the button still held -> no pulse during reset. level_o[0], pulse_o[0] and int_o[0] assert 6 cycles after the first edge following rst deassertion.
